// File: rtl/riscv_pkg.sv
// Shared definitions for the fetch front end: datapath width, instruction size
// and fetch FSM encodings.
package riscv_pkg;
  localparam int XLEN       = 32;
  localparam int INST_BYTES = 4;

  typedef enum logic [1:0] {
    IF_IDLE = 2'd0,
    IF_REQ  = 2'd1,
    IF_DROP = 2'd2
  } if_state_e;
endpackage

// File: rtl/ifetch_unit_fifo.sv
// Small instruction buffer holding {pc, inst} pairs. Synchronous reset clears the
// storage; flush only empties it.
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       head,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    rd_ptr_r;
  logic [AW-1:0]    wr_ptr_r;
  logic [CW-1:0]    count_r;

  // Storage, pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
    end else if (flush) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push) begin
        mem_r[wr_ptr_r] <= wdata;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (pop) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      count_r <= count_r + CW'(push) - CW'(pop);
    end
  end

  assign head  = mem_r[rd_ptr_r];
  assign count = count_r;
endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: owns the PC, issues one outstanding imem request at a
// time, buffers returned words and restarts on redirect.
module ifetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);
  localparam int             CW      = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);
  localparam logic [XLEN-1:0] PC_MASK = ~(XLEN'(INST_BYTES) - XLEN'(1));

  if_state_e         state_r;
  logic [XLEN-1:0]   fetch_pc_r;
  logic [XLEN-1:0]   hold_addr_r;
  logic              push_s;
  logic              pop_s;
  logic [CW-1:0]     count_s;
  logic [CW-1:0]     count_next_s;
  logic [2*XLEN-1:0] head_s;

  // Redirect overrides both FIFO ports in the cycle it is asserted.
  always_comb begin
    pop_s        = inst_valid && inst_ready && !redirect;
    push_s       = (state_r == IF_REQ) && imem_ack && !redirect;
    count_next_s = count_s + CW'(push_s) - CW'(pop_s);
  end

  // Fetch FSM, PC and held address of a request that is being discarded.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IF_IDLE;
      fetch_pc_r  <= RESET_PC;
      hold_addr_r <= '0;
    end else if (redirect) begin
      fetch_pc_r <= redirect_pc & PC_MASK;
      if ((state_r == IF_REQ || state_r == IF_DROP) && !imem_ack) begin
        state_r <= IF_DROP;
        if (state_r == IF_REQ) hold_addr_r <= fetch_pc_r;
      end else begin
        state_r <= IF_REQ;
      end
    end else begin
      case (state_r)
        IF_IDLE: if (count_s < DEPTH_C) state_r <= IF_REQ;
        IF_REQ: begin
          if (imem_ack) begin
            fetch_pc_r <= fetch_pc_r + XLEN'(INST_BYTES);
            state_r    <= (count_next_s < DEPTH_C) ? IF_REQ : IF_IDLE;
          end
        end
        IF_DROP: if (imem_ack) state_r <= IF_REQ;
        default: state_r <= IF_IDLE;
      endcase
    end
  end

  assign imem_req   = (state_r == IF_REQ) || (state_r == IF_DROP);
  assign imem_addr  = (state_r == IF_DROP) ? hold_addr_r : fetch_pc_r;
  assign inst_valid = (count_s != '0);
  assign inst_pc    = head_s[2*XLEN-1:XLEN];
  assign inst       = head_s[XLEN-1:0];

  fetch_fifo #(
    .WIDTH(2 * XLEN),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push_s),
    .pop  (pop_s),
    .flush(redirect),
    .wdata({fetch_pc_r, imem_rdata}),
    .head (head_s),
    .count(count_s)
  );
endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: a queue-based model of the fetch stage plus
// directed scenarios and a randomized soak.
module tb_ifetch_unit;
  localparam logic [31:0] RPC   = 32'h0000_0100;
  localparam int          DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst, imem_req, imem_ack, inst_valid, inst_ready, redirect;
  logic [31:0] imem_addr, imem_rdata, inst, inst_pc, redirect_pc;

  ifetch_unit #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .inst(inst), .inst_pc(inst_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .redirect(redirect),
    .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // model: buffered {pc,inst}, whether a request is out, whether it will be dropped
  logic [63:0] q[$];
  bit          m_out, m_drop;
  logic [31:0] m_pc, m_stale;

  // memory side
  int          lat_left = -1;
  int          fixed_lat = 0;
  logic [31:0] ack_log[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0100) return 32'h00A0_0093;
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    int  sz0;
    bit  ack_v, pop;
    if (rst) begin
      q.delete(); m_out = 0; m_drop = 0; m_pc = RPC;
      return;
    end
    ack_v = imem_ack && m_out;
    if (redirect) begin
      q.delete();
      if (m_out && !ack_v) begin
        if (!m_drop) m_stale = m_pc;
        m_drop = 1;
      end else begin
        m_out = 1; m_drop = 0;
      end
      m_pc = redirect_pc & 32'hFFFF_FFFC;
      return;
    end
    sz0 = q.size();
    pop = (sz0 != 0) && inst_ready;
    if (pop) void'(q.pop_front());
    if (!m_out) begin
      if (sz0 < DEPTH) m_out = 1;
    end else if (ack_v) begin
      if (m_drop) m_drop = 0;
      else begin
        q.push_back({m_pc, mem_word(m_pc)});
        m_pc = m_pc + 32'd4;
        if (sz0 + 1 - int'(pop) >= DEPTH) m_out = 0;
      end
    end
  endtask

  task automatic compare();
    check("imem_req", {31'd0, imem_req}, {31'd0, m_out});
    if (m_out) check("imem_addr", imem_addr, m_drop ? m_stale : m_pc);
    check("inst_valid", {31'd0, inst_valid}, {31'd0, q.size() != 0});
    if (q.size() != 0) begin
      check("inst", inst, q[0][31:0]);
      check("inst_pc", inst_pc, q[0][63:32]);
    end
  endtask

  task automatic step(input bit r, input bit rdy, input bit rd, input logic [31:0] rpc);
    rst = r; inst_ready = rdy; redirect = rd; redirect_pc = rpc;
    if (!imem_req) lat_left = -1;
    else if (lat_left < 0) lat_left = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
    imem_ack   = imem_req && (lat_left == 0);
    imem_rdata = imem_ack ? mem_word(imem_addr) : $urandom;
    if (imem_ack && !r) ack_log.push_back(imem_addr);
    @(posedge clk);
    model_edge();
    if (imem_ack) lat_left = -1;
    else if (lat_left > 0) lat_left--;
    #1;
    compare();
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, 32'd0);
    step(1'b1, 1'b0, 1'b0, 32'd0);
    ack_log.delete();
  endtask

  initial begin
    rst = 1'b1; imem_ack = 1'b0; imem_rdata = 32'd0; inst_ready = 1'b0;
    redirect = 1'b0; redirect_pc = 32'd0;

    // reset state and first fetch
    fixed_lat = 0;
    do_reset();
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_valid", {31'd0, inst_valid}, 32'd0);
    check("rst_inst", inst, 32'd0);
    check("rst_inst_pc", inst_pc, 32'd0);
    step(1'b0, 1'b1, 1'b0, 32'd0);
    check("first_req", {31'd0, imem_req}, 32'd1);
    check("first_addr", imem_addr, 32'h0000_0100);
    step(1'b0, 1'b1, 1'b0, 32'd0);
    check("first_inst", inst, 32'h00A0_0093);
    check("first_pc", inst_pc, 32'h0000_0100);
    check("first_valid", {31'd0, inst_valid}, 32'd1);

    // back-pressure
    do_reset();
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0, 32'd0);
    check("bp_nreq", ack_log.size(), 32'd2);
    if (ack_log.size() >= 2) begin
      check("bp_a0", ack_log[0], 32'h0000_0100);
      check("bp_a1", ack_log[1], 32'h0000_0104);
    end
    check("bp_idle", {31'd0, imem_req}, 32'd0);
    step(1'b0, 1'b1, 1'b0, 32'd0);
    check("bp_pop_pc", inst_pc, 32'h0000_0104);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 32'd0);
    check("bp_nreq2", ack_log.size(), 32'd3);
    if (ack_log.size() >= 3) check("bp_a2", ack_log[2], 32'h0000_0108);

    // slow memory, then redirect mid-flight
    fixed_lat = 3;
    do_reset();
    for (int i = 0; i < 40 && ack_log.size() < 3; i++) step(1'b0, 1'b1, 1'b0, 32'd0);
    check("slow_n", ack_log.size(), 32'd3);
    if (ack_log.size() >= 3) check("slow_a2", ack_log[2], 32'h0000_0108);
    do_reset();
    for (int i = 0; i < 20 && ack_log.size() < 1; i++) step(1'b0, 1'b1, 1'b0, 32'd0);
    step(1'b0, 1'b1, 1'b0, 32'd0);
    step(1'b0, 1'b1, 1'b1, 32'h0000_2003);
    check("rd_flush", {31'd0, inst_valid}, 32'd0);
    check("rd_hold", imem_addr, 32'h0000_0104);
    for (int i = 0; i < 20 && ack_log.size() < 3; i++) step(1'b0, 1'b1, 1'b0, 32'd0);
    check("rd_n", ack_log.size(), 32'd3);
    if (ack_log.size() >= 3) begin
      check("rd_stale", ack_log[1], 32'h0000_0104);
      check("rd_new", ack_log[2], 32'h0000_2000);
    end
    check("rd_pc", inst_pc, 32'h0000_2000);

    // simultaneous redirect + ack + ready, wrap-around, reset mid-request
    fixed_lat = 0;
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 32'd0);
    step(1'b0, 1'b1, 1'b1, 32'h0000_3000);
    check("sim_valid", {31'd0, inst_valid}, 32'd0);
    check("sim_addr", imem_addr, 32'h0000_3000);
    step(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFE);
    step(1'b0, 1'b1, 1'b0, 32'd0);
    check("wrap_pc0", inst_pc, 32'hFFFF_FFFC);
    step(1'b0, 1'b1, 1'b0, 32'd0);
    check("wrap_pc1", inst_pc, 32'h0000_0000);
    check("wrap_valid", {31'd0, inst_valid}, 32'd1);
    step(1'b1, 1'b1, 1'b0, 32'd0);
    check("mrst_req", {31'd0, imem_req}, 32'd0);
    check("mrst_valid", {31'd0, inst_valid}, 32'd0);
    check("mrst_inst", inst, 32'd0);
    step(1'b0, 1'b1, 1'b0, 32'd0);
    check("mrst_addr", imem_addr, RPC);

    // randomized soak
    fixed_lat = -1;
    for (int i = 0; i < 4000; i++) begin
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 15) == 0), $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
